// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a byte stream into 256 x 16 words and
// then feeds a pipelined CPU decode stage, with run/halt/drain/stop sequencing.
module imem_loader #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        run_req,
  input  logic        stop_req,
  input  logic [7:0]  pc,
  output logic [15:0] id_ir,
  output logic        start,
  output logic        enable,
  output logic [8:0]  word_count,
  output logic        load_err
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_HI, S_LOAD_LO, S_READY, S_RUN, S_DRAIN
  } state_t;

  state_t          r_state;
  logic [15:0]     r_mem [256];
  logic [255:0]    r_valid;
  logic [7:0]      r_hi;
  logic [8:0]      r_wcount;
  logic            r_err;
  logic            r_start;
  logic            r_enable;
  logic [CW-1:0]   r_drain_cnt;

  logic            w_ld_ready;
  logic            w_first;
  logic            w_xfer;
  logic            w_full;
  logic            w_we;
  logic [7:0]      w_waddr;
  logic [15:0]     w_wdata;
  logic            w_exec;
  logic            w_halt;

  assign w_ld_ready = (r_state != S_RUN) && (r_state != S_DRAIN);
  assign w_exec     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign id_ir      = (w_exec && r_valid[pc]) ? r_mem[pc] : 16'h0000;
  assign w_halt     = (id_ir[15:11] == 5'b00001);

  // A first byte in IDLE/READY restarts the load, so the count is treated as 0.
  always_comb begin
    w_first = (r_state == S_IDLE) || (r_state == S_READY);
    w_xfer  = ld_valid && w_ld_ready;
    w_full  = r_wcount[8] && !w_first;
    w_waddr = w_first ? 8'd0 : r_wcount[7:0];
    w_we    = 1'b0;
    w_wdata = {r_hi, ld_data};
    if (w_xfer && !w_full) begin
      if (r_state == S_LOAD_LO) begin
        w_we = 1'b1;
      end else if (ld_last) begin
        w_we    = 1'b1;
        w_wdata = {ld_data, 8'h00};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_we && reset) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clock) begin
    if (w_xfer && (r_state != S_LOAD_LO)) r_hi <= ld_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_wcount    <= '0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_enable    <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE, S_LOAD_HI, S_LOAD_LO, S_READY: begin
          if (w_xfer) begin
            if (w_first) begin
              r_valid <= '0;
              r_err   <= 1'b0;
            end
            if (w_full) r_err <= 1'b1;
            if (w_we) begin
              r_valid[w_waddr] <= 1'b1;
              r_wcount         <= w_first ? 9'd1 : r_wcount + 9'd1;
            end else if (w_first) begin
              r_wcount <= '0;
            end
            if (r_state == S_LOAD_LO) begin
              r_state <= ld_last ? S_READY : S_LOAD_HI;
            end else if (ld_last) begin
              r_err   <= 1'b1;
              r_state <= S_READY;
            end else begin
              r_state <= S_LOAD_LO;
            end
          end else if ((r_state == S_READY) && run_req && (r_wcount != 9'd0)) begin
            r_start  <= 1'b1;
            r_enable <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop_req) begin
            r_enable <= 1'b0;
            r_state  <= S_READY;
          end else if (w_halt) begin
            r_drain_cnt <= '0;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (stop_req || (r_drain_cnt == DRAIN_LAST)) begin
            r_enable <= 1'b0;
            r_state  <= S_READY;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: begin
          r_enable <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ld_ready   = w_ld_ready;
  assign start      = r_start;
  assign enable     = r_enable;
  assign word_count = r_wcount;
  assign load_err   = r_err;

endmodule
